cpm_reg_slave: RTL and testbench
================================

CPM_REG_SLAVE -- requirements
Module: cpm_reg_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, with all state updated on posedge clk.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning idle cycles inserted between request acceptance and gnt.
REQ-003 Port clk  input  1  system clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port req  input  1  register-bus request from the master.
REQ-006 Port write_en  input  1  1 = write, 0 = read.
REQ-007 Port addr  input  8  byte address.
REQ-008 Port wdata  input  32  write data.
REQ-009 Port gnt  output  1  one-cycle completion pulse.
REQ-010 Port rdata  output  32  read data, valid only while gnt=1.
REQ-011 Port cnt_in_inc  input  1  input-stream handshake pulse, counted.
REQ-012 Port cnt_out_inc  input  1  output-stream handshake pulse, counted.
REQ-013 Port cnt_drop_inc  input  1  packet-drop pulse, counted.
REQ-014 Port cfg_enable  output  1  CTRL[0].
REQ-015 Port cfg_mode  output  4  CTRL[7:4].
REQ-016 Port cfg_drop_opcode  output  4  DROP_CFG[3:0].

Function
REQ-017 Register map SHALL be: 0x00 CTRL RW ([0] enable, [7:4] mode); 0x04 DROP_CFG RW ([3:0]); 0x08 IN_CNT RO; 0x0C OUT_CNT RO; 0x10 DROP_CNT RO; 0x14 STATUS ([0] addr_err, sticky, W1C); 0x18 CNT_CLR WO (write bit0=1 clears all counters).
REQ-018 Unimplemented bits, and CNT_CLR on read, SHALL read 0.
REQ-019 FSM states SHALL be IDLE, WAIT, RESP.
REQ-020 IDLE SHALL accept a request when req=1 at a posedge, latching write_en, addr and wdata, then go to WAIT (if WAIT_STATES>0) or RESP.
REQ-021 WAIT SHALL last exactly WAIT_STATES cycles, then go to RESP.
REQ-022 RESP SHALL drive gnt=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 gnt SHALL therefore rise WAIT_STATES+1 cycles after the acceptance edge.
REQ-024 A write SHALL take effect at the RESP-entry edge.
REQ-025 rdata SHALL be the register value at the RESP-entry edge, before any same-edge counter update, and SHALL hold 0 when gnt=0.
REQ-026 req SHALL be ignored in WAIT and RESP; the master holds req and its fields stable until gnt.
REQ-027 req high in IDLE on the cycle after RESP SHALL start a new transaction, so the minimum issue interval is WAIT_STATES+2 cycles.
REQ-028 An access to an unmapped or non-word-aligned address, or a write to a RO register, SHALL still complete with gnt, have no register effect, and read 0.
REQ-029 Unmapped or misaligned accesses SHALL set STATUS.addr_err; writes to RO registers SHALL NOT set it.
REQ-030 Each counter SHALL be 32-bit, increment by 1 per cycle its inc input is 1, and wrap from 0xFFFFFFFF to 0.
REQ-031 A CNT_CLR clear and an increment in the same cycle SHALL leave the counter at 0 (clear wins).
REQ-032 An addr_err set and a STATUS W1C in the same cycle SHALL leave addr_err at 1 (set wins).
REQ-033 The cfg_* outputs SHALL be driven directly from the register flops (no combinational path from bus inputs).

Reset
REQ-034 rst SHALL force FSM=IDLE, gnt=0, rdata=0, CTRL=0, DROP_CFG=0xF, all counters=0 and addr_err=0 at the next posedge.
REQ-035 rst asserted mid-transaction SHALL abort it with no gnt and no register write.
REQ-036 rst SHALL take priority over all increments and writes.

Structure
REQ-037 Package cpm_reg_pkg SHALL hold the address constants, the FSM state enum, the reset values and a WAIT_STATES max of 7.
REQ-038 Counters SHALL be a sub-module cpm_event_counter (inc, clr, 32-bit count), instantiated three times.

Verification
REQ-039 With WAIT_STATES=1, write CTRL=0x0000_00A1 then read it -> gnt 2 cycles after each acceptance; cfg_enable=1; cfg_mode=0xA; rdata=0x0000_00A1.
REQ-040 Read DROP_CFG after reset -> rdata=0x0000_000F; read 0x03 -> rdata=0, STATUS reads 0x1; write STATUS 0x1 -> STATUS reads 0.
REQ-041 Pulse cnt_in_inc 5 cycles, then read IN_CNT -> 5; write CNT_CLR=1 in the same cycle as cnt_in_inc=1 -> IN_CNT reads 0.
REQ-042 Force DROP_CNT to 0xFFFF_FFFF (via bind/force), pulse cnt_drop_inc once -> reads 0.
REQ-043 Assert rst during WAIT of a CTRL write of 0x1 -> no gnt; CTRL reads 0 after reset.
REQ-044 Hold req high continuously with WAIT_STATES=0 -> gnt pulses every 2 cycles; no gnt is ever high for 2 consecutive cycles.

Source files
------------

// File: rtl/cpm_reg_pkg.sv
// cpm_reg_pkg
// Shared constants for the CPM register slave: register byte addresses,
// reset values of the configuration fields, the upper limit on inserted
// wait states, and the bus-handshake FSM state encoding.
package cpm_reg_pkg;

  // Register byte addresses (all word aligned)
  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DROP_CFG = 8'h04;
  localparam logic [7:0] ADDR_IN_CNT   = 8'h08;
  localparam logic [7:0] ADDR_OUT_CNT  = 8'h0C;
  localparam logic [7:0] ADDR_DROP_CNT = 8'h10;
  localparam logic [7:0] ADDR_STATUS   = 8'h14;
  localparam logic [7:0] ADDR_CNT_CLR  = 8'h18;

  // Reset values of the writable fields
  localparam logic       CTRL_ENABLE_RST = 1'b0;
  localparam logic [3:0] CTRL_MODE_RST   = 4'h0;
  localparam logic [3:0] DROP_CFG_RST    = 4'hF;

  // Largest supported number of inserted wait states
  localparam int unsigned WAIT_STATES_MAX = 7;

  // Bus handshake FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cpm_event_counter.sv
// cpm_event_counter
// 32-bit free-running event counter that wraps to zero after 0xFFFFFFFF.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - add one to the count on this cycle
//   clr   - clear the count on this cycle (takes priority over inc)
//   count - current counter value
module cpm_event_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  logic [31:0] value;

  // Clear beats a coincident increment so a software clear always lands on 0
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 32'd1;
    end
  end

  assign count = value;

endmodule

// File: rtl/cpm_reg_slave.sv
// cpm_reg_slave
// Register-bus slave holding packet-path configuration, three event counters
// and a sticky address-error flag. Each request is accepted in IDLE, padded
// by WAIT_STATES idle cycles, and completed with a single-cycle gnt pulse.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   req, write_en     - request strobe and direction (1 = write)
//   addr, wdata       - byte address and write data
//   gnt, rdata        - completion pulse and read data (0 while gnt=0)
//   cnt_*_inc         - event pulses counted by IN/OUT/DROP counters
//   cfg_enable        - CTRL[0]
//   cfg_mode          - CTRL[7:4]
//   cfg_drop_opcode   - DROP_CFG[3:0]
module cpm_reg_slave
  import cpm_reg_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        write_en,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic [31:0] rdata,
  input  logic        cnt_in_inc,
  input  logic        cnt_out_inc,
  input  logic        cnt_drop_inc,
  output logic        cfg_enable,
  output logic [3:0]  cfg_mode,
  output logic [3:0]  cfg_drop_opcode
);

  // Out-of-range parameter values are clamped to the supported maximum
  localparam int unsigned WS_EFF =
    (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0] WAIT_LAST = (WS_EFF == 0) ? 3'd0 : 3'(WS_EFF - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  wait_cnt;

  logic        lat_we;
  logic [7:0]  lat_addr;
  logic [31:0] lat_wdata;

  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic        resp_entry;

  logic        ctrl_enable;
  logic [3:0]  ctrl_mode;
  logic [3:0]  drop_cfg;
  logic        addr_err;

  logic        addr_hit;
  logic [31:0] read_value;
  logic        wr_ctrl;
  logic        wr_drop_cfg;
  logic        status_w1c;
  logic        cnt_clr;
  logic        err_set;

  logic [31:0] in_count;
  logic [31:0] out_count;
  logic [31:0] drop_count;

  logic        unused_wdata;

  // State register and the per-wait-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Next-state logic; RESP always lasts one cycle and returns to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (WS_EFF == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the acceptance edge is also the completion edge,
  // so the live bus fields are used directly instead of the latched copies
  assign acc_we     = (state == IDLE) ? write_en : lat_we;
  assign acc_addr   = (state == IDLE) ? addr     : lat_addr;
  assign acc_wdata  = (state == IDLE) ? wdata    : lat_wdata;
  assign resp_entry = (next_state == RESP) && (state != RESP);

  assign unused_wdata = ^acc_wdata[31:8];

  // Address decode: only exact word-aligned register addresses hit
  always_comb begin
    addr_hit = 1'b0;
    case (acc_addr)
      ADDR_CTRL, ADDR_DROP_CFG, ADDR_IN_CNT, ADDR_OUT_CNT,
      ADDR_DROP_CNT, ADDR_STATUS, ADDR_CNT_CLR: addr_hit = 1'b1;
      default:                                  addr_hit = 1'b0;
    endcase
  end

  // Read mux; writes, CNT_CLR and unmapped addresses all return 0
  always_comb begin
    read_value = '0;
    if (!acc_we) begin
      case (acc_addr)
        ADDR_CTRL:     read_value = {24'd0, ctrl_mode, 3'd0, ctrl_enable};
        ADDR_DROP_CFG: read_value = {28'd0, drop_cfg};
        ADDR_IN_CNT:   read_value = in_count;
        ADDR_OUT_CNT:  read_value = out_count;
        ADDR_DROP_CNT: read_value = drop_count;
        ADDR_STATUS:   read_value = {31'd0, addr_err};
        default:       read_value = '0;
      endcase
    end
  end

  // Side effects all happen on the edge that enters RESP
  assign wr_ctrl     = resp_entry && acc_we && (acc_addr == ADDR_CTRL);
  assign wr_drop_cfg = resp_entry && acc_we && (acc_addr == ADDR_DROP_CFG);
  assign status_w1c  = resp_entry && acc_we && (acc_addr == ADDR_STATUS) && acc_wdata[0];
  assign cnt_clr     = resp_entry && acc_we && (acc_addr == ADDR_CNT_CLR) && acc_wdata[0];
  assign err_set     = resp_entry && !addr_hit;

  // Request latch, response outputs and the configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      gnt         <= 1'b0;
      rdata       <= '0;
      ctrl_enable <= CTRL_ENABLE_RST;
      ctrl_mode   <= CTRL_MODE_RST;
      drop_cfg    <= DROP_CFG_RST;
      addr_err    <= 1'b0;
    end else begin
      if ((state == IDLE) && req) begin
        lat_we    <= write_en;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
      gnt   <= resp_entry;
      rdata <= resp_entry ? read_value : 32'd0;
      if (wr_ctrl) begin
        ctrl_enable <= acc_wdata[0];
        ctrl_mode   <= acc_wdata[7:4];
      end
      if (wr_drop_cfg) begin
        drop_cfg <= acc_wdata[3:0];
      end
      // A new error outranks a simultaneous clear
      if (err_set) begin
        addr_err <= 1'b1;
      end else if (status_w1c) begin
        addr_err <= 1'b0;
      end
    end
  end

  cpm_event_counter u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_in_inc),
    .clr   (cnt_clr),
    .count (in_count)
  );

  cpm_event_counter u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_out_inc),
    .clr   (cnt_clr),
    .count (out_count)
  );

  cpm_event_counter u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_drop_inc),
    .clr   (cnt_clr),
    .count (drop_count)
  );

  assign cfg_enable      = ctrl_enable;
  assign cfg_mode        = ctrl_mode;
  assign cfg_drop_opcode = drop_cfg;

endmodule

// File: tb/tb_cpm_reg_slave.sv
// tb_cpm_reg_slave
// Directed bench for cpm_reg_slave: a table of register transactions with
// hand-computed results on a WAIT_STATES=1 instance, hand-written sequences
// for counters, clear/increment collision, wrap, reset abort, and a
// WAIT_STATES=0 instance driven with req held high.
module tb_cpm_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        write_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        cnt_in_inc;
  logic        cnt_out_inc;
  logic        cnt_drop_inc;
  logic        cfg_enable;
  logic [3:0]  cfg_mode;
  logic [3:0]  cfg_drop_opcode;

  logic        req0;
  logic        gnt0;
  logic [31:0] rdata0;
  logic        cfg_enable0;
  logic [3:0]  cfg_mode0;
  logic [3:0]  cfg_drop_opcode0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_en;
    logic [3:0]  exp_mode;
    logic [3:0]  exp_drop;
  } vec_t;

  vec_t vecs[24];

  always #5 clk = ~clk;

  cpm_reg_slave #(.WAIT_STATES(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .write_en        (write_en),
    .addr            (addr),
    .wdata           (wdata),
    .gnt             (gnt),
    .rdata           (rdata),
    .cnt_in_inc      (cnt_in_inc),
    .cnt_out_inc     (cnt_out_inc),
    .cnt_drop_inc    (cnt_drop_inc),
    .cfg_enable      (cfg_enable),
    .cfg_mode        (cfg_mode),
    .cfg_drop_opcode (cfg_drop_opcode)
  );

  cpm_reg_slave #(.WAIT_STATES(0)) dut0 (
    .clk             (clk),
    .rst             (rst),
    .req             (req0),
    .write_en        (1'b0),
    .addr            (8'h04),
    .wdata           (32'd0),
    .gnt             (gnt0),
    .rdata           (rdata0),
    .cnt_in_inc      (1'b0),
    .cnt_out_inc     (1'b0),
    .cnt_drop_inc    (1'b0),
    .cfg_enable      (cfg_enable0),
    .cfg_mode        (cfg_mode0),
    .cfg_drop_opcode (cfg_drop_opcode0)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One bus transaction; incs is held on {drop,out,in} until gnt is seen.
  // lat is the number of posedges from acceptance to gnt (99 on timeout).
  task automatic applyStimulus(input logic we, input logic [7:0] a,
                               input logic [31:0] d, input logic [2:0] incs,
                               output logic [31:0] rd, output int lat);
    bit seen;
    @(negedge clk);
    req      = 1'b1;
    write_en = we;
    addr     = a;
    wdata    = d;
    {cnt_drop_inc, cnt_out_inc, cnt_in_inc} = incs;
    seen = 1'b0;
    lat  = 99;
    rd   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (gnt) begin
        seen = 1'b1;
        lat  = i;
        rd   = rdata;
        break;
      end
    end
    @(negedge clk);
    req = 1'b0;
    write_en = 1'b0;
    {cnt_drop_inc, cnt_out_inc, cnt_in_inc} = 3'b000;
    if (seen) begin
      @(posedge clk);
      #1;
      checkOutput("gnt_one_cycle", {31'd0, gnt}, 32'd0);
      checkOutput("rdata_zero_idle", rdata, 32'd0);
    end
  endtask

  task automatic readReg(input string name, input logic [7:0] a,
                         input logic [31:0] expected);
    logic [31:0] rd;
    int          lat;
    applyStimulus(1'b0, a, 32'd0, 3'b000, rd, lat);
    checkOutput({name, "_lat"}, 32'(lat), 32'd2);
    checkOutput(name, rd, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          gnt0_prev;

    vecs[0]  = '{1'b0, 8'h04, 32'h0,        1'b1, 32'h0000_000F, 1'b0, 4'h0, 4'hF};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 4'h0, 4'hF};
    vecs[2]  = '{1'b1, 8'h00, 32'h0000_00A1, 1'b0, 32'h0,        1'b1, 4'hA, 4'hF};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0000_00A1, 1'b1, 4'hA, 4'hF};
    vecs[4]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, 4'hF, 4'hF};
    vecs[5]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0000_00F1, 1'b1, 4'hF, 4'hF};
    vecs[6]  = '{1'b1, 8'h04, 32'hFFFF_FF03, 1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[7]  = '{1'b0, 8'h04, 32'h0,        1'b1, 32'h0000_0003, 1'b1, 4'hF, 4'h3};
    vecs[8]  = '{1'b0, 8'h03, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[9]  = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0001, 1'b1, 4'hF, 4'h3};
    vecs[10] = '{1'b1, 8'h14, 32'h1,        1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[11] = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[12] = '{1'b1, 8'h08, 32'h55,       1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[13] = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[14] = '{1'b0, 8'h08, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[15] = '{1'b0, 8'h1C, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[16] = '{1'b1, 8'h14, 32'h0,        1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[17] = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0001, 1'b1, 4'hF, 4'h3};
    vecs[18] = '{1'b1, 8'h14, 32'h1,        1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[19] = '{1'b0, 8'h18, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[20] = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 4'hF, 4'h3};
    vecs[21] = '{1'b1, 8'h01, 32'h0,        1'b0, 32'h0,        1'b1, 4'hF, 4'h3};
    vecs[22] = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0000_0001, 1'b1, 4'hF, 4'h3};
    vecs[23] = '{1'b1, 8'h14, 32'h1,        1'b0, 32'h0,        1'b1, 4'hF, 4'h3};

    rst = 1'b1;
    req = 1'b0;
    write_en = 1'b0;
    addr = '0;
    wdata = '0;
    cnt_in_inc = 1'b0;
    cnt_out_inc = 1'b0;
    cnt_drop_inc = 1'b0;
    req0 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt", {31'd0, gnt}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_cfg_enable", {31'd0, cfg_enable}, 32'd0);
    checkOutput("rst_cfg_mode", {28'd0, cfg_mode}, 32'd0);
    checkOutput("rst_cfg_drop", {28'd0, cfg_drop_opcode}, 32'hF);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] register table, %0d vectors", 24);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 3'b000, rd, lat);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      if (vecs[i].chk_rd) begin
        checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      checkOutput($sformatf("vec%0d_cfg_enable", i), {31'd0, cfg_enable}, {31'd0, vecs[i].exp_en});
      checkOutput($sformatf("vec%0d_cfg_mode", i), {28'd0, cfg_mode}, {28'd0, vecs[i].exp_mode});
      checkOutput($sformatf("vec%0d_cfg_drop", i), {28'd0, cfg_drop_opcode}, {28'd0, vecs[i].exp_drop});
    end

    $display("[TB] counters");
    @(negedge clk);
    cnt_in_inc = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    cnt_in_inc = 1'b0;
    readReg("in_cnt_five", 8'h08, 32'd5);
    readReg("out_cnt_zero", 8'h0C, 32'd0);

    // Increment held on both the acceptance and the clearing edge
    applyStimulus(1'b1, 8'h18, 32'h1, 3'b001, rd, lat);
    checkOutput("cnt_clr_lat", 32'(lat), 32'd2);
    readReg("in_cnt_clear_wins", 8'h08, 32'd0);

    // Read returns the value before the same-edge increment
    applyStimulus(1'b0, 8'h0C, 32'h0, 3'b010, rd, lat);
    checkOutput("out_cnt_pre_update", rd, 32'd1);
    readReg("out_cnt_after", 8'h0C, 32'd2);

    $display("[TB] drop counter wrap");
    @(negedge clk);
    force dut.u_drop_cnt.value = 32'hFFFF_FFFF;
    readReg("drop_cnt_forced", 8'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    release dut.u_drop_cnt.value;
    cnt_drop_inc = 1'b1;
    @(negedge clk);
    cnt_drop_inc = 1'b0;
    readReg("drop_cnt_wrap", 8'h10, 32'd0);

    $display("[TB] reset during wait");
    @(negedge clk);
    req = 1'b1;
    write_en = 1'b1;
    addr = 8'h00;
    wdata = 32'h1;
    @(posedge clk);
    #1;
    checkOutput("abort_gnt_wait", {31'd0, gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_gnt_rst", {31'd0, gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat = lat + int'(gnt);
    end
    checkOutput("abort_no_gnt", 32'(lat), 32'd0);
    checkOutput("abort_cfg_enable", {31'd0, cfg_enable}, 32'd0);
    readReg("abort_ctrl", 8'h00, 32'd0);
    readReg("abort_drop_cfg", 8'h04, 32'hF);
    readReg("abort_out_cnt", 8'h0C, 32'd0);

    $display("[TB] back-to-back with zero wait states");
    @(negedge clk);
    req0 = 1'b1;
    gnt0_prev = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("ws0_gnt_c%0d", i), {31'd0, gnt0}, 32'(i % 2));
      checkOutput($sformatf("ws0_no_double_c%0d", i), 32'(gnt0_prev & int'(gnt0)), 32'd0);
      if (gnt0) begin
        checkOutput($sformatf("ws0_rdata_c%0d", i), rdata0, 32'hF);
      end
      gnt0_prev = int'(gnt0);
    end
    @(negedge clk);
    req0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
